id_ex_stage_reg: RTL and testbench
==================================

Name: id_ex_stage_reg

Overview:
ID/EX pipeline register of the 5-stage pipelined RISC-V CPU. It captures decoded control and operand data from the decode stage, then presents them to the execute stage. Its ALU_opc, func3 and func7 outputs feed the ALU controller directly.
It supports hold (stall), bubble insertion (flush) and a valid bit, and it counts inserted bubbles for debug.

Parameters:
XLEN, 32, data/address width
CNT_W, 16, width of bubble counter

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous reset, active-low (0 = reset)
stall  in  1  hold current contents (from hazard unit)
flush  in  1  replace next contents with bubble (load-use or taken branch/jump)
valid_d  in  1  decode-stage instruction valid
ALU_opc_d  in  2  ALU op class: 00 SW_LW, 01 BEQ, 10 RT_IT, 11 IT
func3_d  in  3  instruction func3
func7_d  in  7  instruction func7
reg_write_d  in  1  register-file write enable
mem_write_d  in  1  data-memory write
result_src_d  in  2  writeback mux select
alu_src_d  in  1  ALU B source (0 reg, 1 imm)
branch_d  in  1  conditional branch
jump_d  in  1  jal/jalr
pc_d  in  XLEN  instruction PC
pc_plus4_d  in  XLEN  PC+4
rd1_d  in  XLEN  rs1 read data
rd2_d  in  XLEN  rs2 read data
imm_d  in  XLEN  extended immediate
rs1_d  in  5  rs1 index
rs2_d  in  5  rs2 index
rd_d  in  5  rd index
*_e  out  same  registered copy of every *_d input above (valid_e, ALU_opc_e, ..., rd_e)
bubble_cnt  out  CNT_W  number of bubbles inserted since reset

Behaviour:
- Reset (rst=0, asynchronous):
  - All *_e outputs = 0. ALU_opc_e = 00, so the ALU controller yields ADD.
  - valid_e = 0.
  - bubble_cnt = 0.
  - Reset takes effect immediately, including mid-stall or mid-flush.
- Each rising edge with rst=1, priority flush > stall > load:
  - flush=1: bubble. valid_e, reg_write_e, mem_write_e, branch_e, jump_e, alu_src_e = 0; result_src_e = 00; ALU_opc_e = 00; func3_e = func7_e = 0. Data and index fields (pc, rd1, rd2, imm, rs1, rs2, rd) = 0. bubble_cnt increments.
  - flush=0, stall=1: all *_e hold their values; bubble_cnt holds.
  - else: all *_e <= *_d.
- Latency: one cycle, input to output.
- Input valid_d=0 while loading: the fields are still loaded, but reg_write_e, mem_write_e, branch_e and jump_e are forced to 0. A non-valid entry must never commit state. This is not counted as a bubble.
- flush and stall asserted together: flush wins. The bubble is counted.
- bubble_cnt saturates at 2^CNT_W-1 and does not wrap.
- Outputs are driven only from flops; no combinational path from *_d to *_e.
- The ALU_opc/func3/func7 encodings pass through unmodified. Illegal func combinations are not filtered here.

Decomposition:
- Shared package/header holds:
  - ALU_opc codes: SW_LW=2'b00, BEQ=2'b01, RT_IT=2'b10, IT=2'b11.
  - result_src encodings.
  - Bubble constants: control zero and ALU_opc = SW_LW.
- One natural sub-module: pipe_field_reg, a parameterised-width flop with async active-low reset, enable (load) and synchronous clear (flush). It is instantiated once per field group (control, data, index).
- The saturating counter stays inline.

Test Plan:
- Reset: drive rst=0 mid-cycle with valid inputs present -> all *_e = 0 and bubble_cnt = 0 immediately, without waiting for a clock edge.
- Normal load: ALU_opc_d=10, func3_d=0, func7_d=0x20, rd1_d=5, rd2_d=3, rd_d=7, reg_write_d=1, valid_d=1 -> the next cycle shows those exact values on *_e.
- Stall: load pc_d=0x10, then hold stall=1 for 3 cycles while changing pc_d to 0x14, 0x18, 0x1C -> pc_e stays 0x10 throughout and bubble_cnt is unchanged. After stall drops, pc_e = current pc_d.
- Flush with stall: stall=1 and flush=1 in the same cycle, with reg_write_d=1 and ALU_opc_d=11 -> reg_write_e=0, ALU_opc_e=00, valid_e=0, bubble_cnt increments by 1.
- Invalid input: valid_d=0, mem_write_d=1, jump_d=1, imm_d=0xABC -> mem_write_e=0, jump_e=0, imm_e=0xABC, bubble_cnt unchanged.
- Saturation: with CNT_W=4, apply 20 consecutive flushes -> bubble_cnt reaches 15 and stays at 15.

Source files
------------

// File: rtl/id_ex_stage_reg_pkg.sv
// Shared encodings and bubble constants for the ID/EX pipeline register.
// The control bundle is packed here so the top and its bench agree on layout.
package id_ex_stage_reg_pkg;

  typedef enum logic [1:0] {
    ALU_SW_LW = 2'b00,
    ALU_BEQ   = 2'b01,
    ALU_RT_IT = 2'b10,
    ALU_IT    = 2'b11
  } alu_opc_t;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10,
    RES_IMM = 2'b11
  } result_src_t;

  typedef struct packed {
    logic       valid;
    logic [1:0] alu_opc;
    logic [2:0] func3;
    logic [6:0] func7;
    logic       reg_write;
    logic       mem_write;
    logic [1:0] result_src;
    logic       alu_src;
    logic       branch;
    logic       jump;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);
  localparam int IDX_W  = 15;

  // A bubble is an invalid ADD (SW_LW class) that writes nothing.
  localparam ctrl_t CTRL_BUBBLE = '{
    valid:      1'b0,
    alu_opc:    ALU_SW_LW,
    func3:      3'd0,
    func7:      7'd0,
    reg_write:  1'b0,
    mem_write:  1'b0,
    result_src: RES_ALU,
    alu_src:    1'b0,
    branch:     1'b0,
    jump:       1'b0
  };

  // An entry that is not valid keeps its fields but may never commit state.
  function automatic ctrl_t gate_ctrl(input ctrl_t c);
    ctrl_t g;
    g = c;
    if (!c.valid) begin
      g.reg_write = 1'b0;
      g.mem_write = 1'b0;
      g.branch    = 1'b0;
      g.jump      = 1'b0;
    end
    return g;
  endfunction

endpackage

// File: rtl/id_ex_stage_reg_field.sv
// Generic pipeline field register: async active-low reset, load enable and
// synchronous clear; clear outranks load.
module pipe_field_reg #(
  parameter int           W       = 8,
  parameter logic [W-1:0] CLR_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (clr) begin
      q <= CLR_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register: captures decode outputs for execute, with stall
// (hold), flush (bubble) and a saturating count of inserted bubbles.
module id_ex_stage_reg
  import id_ex_stage_reg_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic             valid_d,
  input  logic [1:0]       ALU_opc_d,
  input  logic [2:0]       func3_d,
  input  logic [6:0]       func7_d,
  input  logic             reg_write_d,
  input  logic             mem_write_d,
  input  logic [1:0]       result_src_d,
  input  logic             alu_src_d,
  input  logic             branch_d,
  input  logic             jump_d,
  input  logic [XLEN-1:0]  pc_d,
  input  logic [XLEN-1:0]  pc_plus4_d,
  input  logic [XLEN-1:0]  rd1_d,
  input  logic [XLEN-1:0]  rd2_d,
  input  logic [XLEN-1:0]  imm_d,
  input  logic [4:0]       rs1_d,
  input  logic [4:0]       rs2_d,
  input  logic [4:0]       rd_d,
  output logic             valid_e,
  output logic [1:0]       ALU_opc_e,
  output logic [2:0]       func3_e,
  output logic [6:0]       func7_e,
  output logic             reg_write_e,
  output logic             mem_write_e,
  output logic [1:0]       result_src_e,
  output logic             alu_src_e,
  output logic             branch_e,
  output logic             jump_e,
  output logic [XLEN-1:0]  pc_e,
  output logic [XLEN-1:0]  pc_plus4_e,
  output logic [XLEN-1:0]  rd1_e,
  output logic [XLEN-1:0]  rd2_e,
  output logic [XLEN-1:0]  imm_e,
  output logic [4:0]       rs1_e,
  output logic [4:0]       rs2_e,
  output logic [4:0]       rd_e,
  output logic [CNT_W-1:0] bubble_cnt
);

  localparam int DATA_W = 5 * XLEN;

  // Handshake: there is no backpressure port; valid_e marks a real
  // instruction, stall freezes every field, flush overrides stall and loads
  // an invalid bubble on the same edge.
  logic              load_en;
  ctrl_t             ctrl_d;
  ctrl_t             ctrl_q;
  logic [DATA_W-1:0] data_d;
  logic [DATA_W-1:0] data_q;
  logic [IDX_W-1:0]  idx_d;
  logic [IDX_W-1:0]  idx_q;

  assign load_en = flush | ~stall;

  always_comb begin
    ctrl_d = gate_ctrl('{
      valid:      valid_d,
      alu_opc:    ALU_opc_d,
      func3:      func3_d,
      func7:      func7_d,
      reg_write:  reg_write_d,
      mem_write:  mem_write_d,
      result_src: result_src_d,
      alu_src:    alu_src_d,
      branch:     branch_d,
      jump:       jump_d
    });
  end

  assign data_d = {pc_d, pc_plus4_d, rd1_d, rd2_d, imm_d};
  assign idx_d  = {rs1_d, rs2_d, rd_d};

  pipe_field_reg #(
    .W       (CTRL_W),
    .CLR_VAL (CTRL_BUBBLE)
  ) u_ctrl (
    .clk (clk),
    .rst (rst),
    .en  (load_en),
    .clr (flush),
    .d   (ctrl_d),
    .q   (ctrl_q)
  );

  pipe_field_reg #(
    .W       (DATA_W),
    .CLR_VAL ('0)
  ) u_data (
    .clk (clk),
    .rst (rst),
    .en  (load_en),
    .clr (flush),
    .d   (data_d),
    .q   (data_q)
  );

  pipe_field_reg #(
    .W       (IDX_W),
    .CLR_VAL ('0)
  ) u_idx (
    .clk (clk),
    .rst (rst),
    .en  (load_en),
    .clr (flush),
    .d   (idx_d),
    .q   (idx_q)
  );

  assign valid_e      = ctrl_q.valid;
  assign ALU_opc_e    = ctrl_q.alu_opc;
  assign func3_e      = ctrl_q.func3;
  assign func7_e      = ctrl_q.func7;
  assign reg_write_e  = ctrl_q.reg_write;
  assign mem_write_e  = ctrl_q.mem_write;
  assign result_src_e = ctrl_q.result_src;
  assign alu_src_e    = ctrl_q.alu_src;
  assign branch_e     = ctrl_q.branch;
  assign jump_e       = ctrl_q.jump;

  assign {pc_e, pc_plus4_e, rd1_e, rd2_e, imm_e} = data_q;
  assign {rs1_e, rs2_e, rd_e}                    = idx_q;

  // Saturating so a long-running debug session never sees the count wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bubble_cnt <= '0;
    end else if (flush && (bubble_cnt != {CNT_W{1'b1}})) begin
      bubble_cnt <= bubble_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Bench for id_ex_stage_reg: directed vectors feed an expected queue that a
// negedge monitor drains against the registered outputs.
module tb_id_ex_stage_reg;

  localparam int XLEN  = 32;
  localparam int CNT_W = 4;

  typedef struct packed {
    logic            valid;
    logic [1:0]      alu_opc;
    logic [2:0]      func3;
    logic [6:0]      func7;
    logic            reg_write;
    logic            mem_write;
    logic [1:0]      result_src;
    logic            alu_src;
    logic            branch;
    logic            jump;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
  } fields_t;

  typedef struct packed {
    fields_t          f;
    logic [CNT_W-1:0] cnt;
  } out_t;

  localparam int OW = $bits(out_t);

  logic clk, rst, stall, flush;
  fields_t din;
  out_t    act;
  logic             valid_e, reg_write_e, mem_write_e, alu_src_e, branch_e, jump_e;
  logic [1:0]       ALU_opc_e, result_src_e;
  logic [2:0]       func3_e;
  logic [6:0]       func7_e;
  logic [XLEN-1:0]  pc_e, pc_plus4_e, rd1_e, rd2_e, imm_e;
  logic [4:0]       rs1_e, rs2_e, rd_e;
  logic [CNT_W-1:0] bubble_cnt;

  logic [OW-1:0] exp_q[$];
  string         name_q[$];
  out_t          m;
  int            n_checks;
  int            n_fail;

  id_ex_stage_reg #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .flush        (flush),
    .valid_d      (din.valid),
    .ALU_opc_d    (din.alu_opc),
    .func3_d      (din.func3),
    .func7_d      (din.func7),
    .reg_write_d  (din.reg_write),
    .mem_write_d  (din.mem_write),
    .result_src_d (din.result_src),
    .alu_src_d    (din.alu_src),
    .branch_d     (din.branch),
    .jump_d       (din.jump),
    .pc_d         (din.pc),
    .pc_plus4_d   (din.pc_plus4),
    .rd1_d        (din.rd1),
    .rd2_d        (din.rd2),
    .imm_d        (din.imm),
    .rs1_d        (din.rs1),
    .rs2_d        (din.rs2),
    .rd_d         (din.rd),
    .valid_e      (valid_e),
    .ALU_opc_e    (ALU_opc_e),
    .func3_e      (func3_e),
    .func7_e      (func7_e),
    .reg_write_e  (reg_write_e),
    .mem_write_e  (mem_write_e),
    .result_src_e (result_src_e),
    .alu_src_e    (alu_src_e),
    .branch_e     (branch_e),
    .jump_e       (jump_e),
    .pc_e         (pc_e),
    .pc_plus4_e   (pc_plus4_e),
    .rd1_e        (rd1_e),
    .rd2_e        (rd2_e),
    .imm_e        (imm_e),
    .rs1_e        (rs1_e),
    .rs2_e        (rs2_e),
    .rd_e         (rd_e),
    .bubble_cnt   (bubble_cnt)
  );

  always_comb begin
    act = '{
      f: '{valid: valid_e, alu_opc: ALU_opc_e, func3: func3_e, func7: func7_e,
           reg_write: reg_write_e, mem_write: mem_write_e,
           result_src: result_src_e, alu_src: alu_src_e, branch: branch_e,
           jump: jump_e, pc: pc_e, pc_plus4: pc_plus4_e, rd1: rd1_e,
           rd2: rd2_e, imm: imm_e, rs1: rs1_e, rs2: rs2_e, rd: rd_e},
      cnt: bubble_cnt
    };
  end

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [OW-1:0] e;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      n_checks++;
      if (act !== e) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", nm, act, e);
      end
    end
  end

  task automatic check_now(input string nm, input out_t e);
    n_checks++;
    if (act !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, e);
    end
  endtask

  // Driver: apply one cycle of inputs, then queue the reference result.
  task automatic step(input fields_t v, input logic st, input logic fl, input string nm);
    din   = v;
    stall = st;
    flush = fl;
    if (fl) begin
      m.f = '0;
      if (m.cnt != {CNT_W{1'b1}}) m.cnt = m.cnt + 1'b1;
    end else if (!st) begin
      m.f = v;
      if (!v.valid) begin
        m.f.reg_write = 1'b0;
        m.f.mem_write = 1'b0;
        m.f.branch    = 1'b0;
        m.f.jump      = 1'b0;
      end
    end
    @(posedge clk);
    exp_q.push_back(m);
    name_q.push_back(nm);
    #1;
  endtask

  function automatic fields_t vec(input logic vld, input logic [1:0] opc,
                                  input logic [2:0] f3, input logic [6:0] f7,
                                  input logic [XLEN-1:0] pc);
    fields_t v;
    v          = '0;
    v.valid    = vld;
    v.alu_opc  = opc;
    v.func3    = f3;
    v.func7    = f7;
    v.pc       = pc;
    v.pc_plus4 = pc + 32'd4;
    return v;
  endfunction

  initial begin
    fields_t v;
    n_checks = 0;
    n_fail   = 0;
    m        = '0;
    stall    = 1'b0;
    flush    = 1'b0;
    rst      = 1'b0;
    din      = vec(1'b1, 2'b10, 3'd5, 7'h20, 32'h100);
    din.reg_write = 1'b1;
    repeat (2) @(negedge clk);
    check_now("reset_initial", '0);
    #2 rst = 1'b1;

    // Normal load
    v = vec(1'b1, 2'b10, 3'd0, 7'h20, 32'h0);
    v.rd1 = 32'd5; v.rd2 = 32'd3; v.rd = 5'd7; v.reg_write = 1'b1;
    step(v, 1'b0, 1'b0, "normal_load");

    // Stall holds pc 0x10 while pc_d moves on
    step(vec(1'b1, 2'b11, 3'd1, 7'h0, 32'h10), 1'b0, 1'b0, "stall_load");
    step(vec(1'b1, 2'b11, 3'd1, 7'h0, 32'h14), 1'b1, 1'b0, "stall_1");
    step(vec(1'b1, 2'b11, 3'd1, 7'h0, 32'h18), 1'b1, 1'b0, "stall_2");
    step(vec(1'b1, 2'b11, 3'd1, 7'h0, 32'h1C), 1'b1, 1'b0, "stall_3");
    n_checks++;
    if (pc_e !== 32'h10) begin
      n_fail++;
      $display("FAIL stall_pc_hold: got %h expected %h", pc_e, 32'h10);
    end
    step(vec(1'b1, 2'b11, 3'd1, 7'h0, 32'h20), 1'b0, 1'b0, "stall_release");

    // Flush wins over stall
    v = vec(1'b1, 2'b11, 3'd7, 7'h7F, 32'h24);
    v.reg_write = 1'b1; v.rd = 5'd9; v.imm = 32'h55;
    step(v, 1'b1, 1'b1, "flush_with_stall");
    n_checks++;
    if (bubble_cnt !== 4'd1) begin
      n_fail++;
      $display("FAIL flush_cnt: got %0d expected 1", bubble_cnt);
    end

    // Invalid entry keeps fields but loses commit controls
    v = vec(1'b0, 2'b01, 3'd2, 7'h1, 32'h28);
    v.mem_write = 1'b1; v.jump = 1'b1; v.branch = 1'b1; v.reg_write = 1'b1;
    v.imm = 32'hABC; v.rs1 = 5'd3; v.rs2 = 5'd4;
    step(v, 1'b0, 1'b0, "invalid_input");

    // Mixed field patterns
    v = vec(1'b1, 2'b01, 3'd0, 7'h0, 32'hFFFF_FFFC);
    v.branch = 1'b1; v.alu_src = 1'b0; v.result_src = 2'b00;
    v.rd1 = 32'hDEAD_BEEF; v.rd2 = 32'hDEAD_BEEF; v.rs1 = 5'd31; v.rs2 = 5'd1;
    step(v, 1'b0, 1'b0, "branch_vec");
    v = vec(1'b1, 2'b00, 3'd2, 7'h0, 32'h80);
    v.reg_write = 1'b1; v.result_src = 2'b01; v.alu_src = 1'b1;
    v.imm = 32'hFFFF_FFF0; v.rd = 5'd31;
    step(v, 1'b0, 1'b0, "load_vec");
    v = vec(1'b1, 2'b00, 3'd0, 7'h0, 32'h84);
    v.jump = 1'b1; v.reg_write = 1'b1; v.result_src = 2'b10; v.rd = 5'd1;
    step(v, 1'b0, 1'b0, "jal_vec");

    // Asynchronous reset mid-stall
    din = vec(1'b1, 2'b10, 3'd4, 7'h20, 32'h200);
    din.reg_write = 1'b1;
    stall = 1'b1;
    @(negedge clk);
    #2 rst = 1'b0;
    #1 check_now("reset_mid_stall", '0);
    m = '0;
    @(negedge clk);
    #1 rst = 1'b1;
    stall = 1'b0;

    // Saturation of the bubble counter
    for (int i = 0; i < 20; i++) begin
      step(vec(1'b1, 2'b11, 3'd0, 7'h0, 32'h300), 1'b0, 1'b1, $sformatf("sat_%0d", i));
    end
    n_checks++;
    if (bubble_cnt !== 4'd15) begin
      n_fail++;
      $display("FAIL sat_final: got %0d expected 15", bubble_cnt);
    end

    begin
      int budget;
      budget = 0;
      while (exp_q.size() > 0 && budget < 10) begin
        @(posedge clk);
        budget++;
      end
      if (exp_q.size() > 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL drain: got %0d entries left expected 0", exp_q.size());
      end
    end
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
